// File: rtl/csr_trap_unit_if.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module      : csr_trap_unit_if                                             |
// | Description : Decoder <-> CSR/trap unit bus. The decoder (master) presents |
// |               one instruction per cycle with its CSR operands. The CSR     |
// |               unit (slave) returns the old CSR value combinationally and a |
// |               one-cycle redirect strobe with its target.                   |
// | Signals     : instr_valid, pc[31:0], gpr_qa[31:0], csr_op[7:0] (act. low), |
// |               csr_zimm[4:0], csr_addr[11:0], retire  -> slave              |
// |               csr_rdata[31:0], int_flag, int_addr[31:0] -> master          |
// | Revision    : 1.0  initial release                                         |
// +----------------------------------------------------------------------------+
interface csr_trap_unit_if;
  logic        instr_valid;
  logic [31:0] pc;
  logic [31:0] gpr_qa;
  logic [7:0]  csr_op;
  logic [4:0]  csr_zimm;
  logic [11:0] csr_addr;
  logic        retire;
  logic [31:0] csr_rdata;
  logic        int_flag;
  logic [31:0] int_addr;

  modport master (
    output instr_valid, pc, gpr_qa, csr_op, csr_zimm, csr_addr, retire,
    input  csr_rdata, int_flag, int_addr
  );

  modport slave (
    input  instr_valid, pc, gpr_qa, csr_op, csr_zimm, csr_addr, retire,
    output csr_rdata, int_flag, int_addr
  );
endinterface
`default_nettype wire

// File: rtl/csr_trap_unit.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module      : csr_trap_unit                                                |
// | Description : Machine-mode CSR file and trap sequencer. Executes csrrw/s/c |
// |               (immediate forms too), ecall/ebreak/mret, takes MEI/MTI and  |
// |               NUM_LCL local interrupts, raises illegal-CSR exceptions and  |
// |               keeps 64-bit mcycle/minstret. Redirects are registered and   |
// |               strobed for exactly one cycle.                               |
// | Ports       : clk, rst_n (async, active low)                               |
// |               ei, ti, lcl_irq[NUM_LCL-1:0]  async interrupt lines, act low |
// |               bus (csr_trap_unit_if.slave)  decoder bus                    |
// | Revision    : 1.0  initial release                                         |
// +----------------------------------------------------------------------------+
module csr_trap_unit #(
  parameter int          NUM_LCL     = 4,
  parameter bit          VECTORED    = 1'b1,
  parameter logic [31:0] MTVEC_RESET = 32'h0000_0100
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               ei,
  input  logic               ti,
  input  logic [NUM_LCL-1:0] lcl_irq,
  csr_trap_unit_if.slave     bus
);

  localparam int          NI          = NUM_LCL + 2;
  localparam logic [31:0] LCL_MASK    = ((32'd1 << NUM_LCL) - 32'd1) << 16;
  localparam logic [31:0] MIE_WMASK   = 32'h0000_0888 | LCL_MASK;
  localparam logic [31:0] MTVEC_WMASK = VECTORED ? 32'hFFFF_FFFD : 32'hFFFF_FFFC;

  localparam logic [11:0] ADDR_MSTATUS   = 12'h300;
  localparam logic [11:0] ADDR_MIE       = 12'h304;
  localparam logic [11:0] ADDR_MTVEC     = 12'h305;
  localparam logic [11:0] ADDR_MSCRATCH  = 12'h340;
  localparam logic [11:0] ADDR_MEPC      = 12'h341;
  localparam logic [11:0] ADDR_MCAUSE    = 12'h342;
  localparam logic [11:0] ADDR_MIP       = 12'h344;
  localparam logic [11:0] ADDR_MCYCLE    = 12'hB00;
  localparam logic [11:0] ADDR_MINSTRET  = 12'hB02;
  localparam logic [11:0] ADDR_MCYCLEH   = 12'hB80;
  localparam logic [11:0] ADDR_MINSTRETH = 12'hB82;

  typedef enum logic [0:0] {
    ST_RUN   = 1'b0,
    ST_REDIR = 1'b1
  } state_t;

  state_t        state_q, state_d;
  logic          mstatus_mie_q, mstatus_mie_d;
  logic          mstatus_mpie_q, mstatus_mpie_d;
  logic [31:0]   mie_q, mie_d;
  logic [31:0]   mtvec_q, mtvec_d;
  logic [31:0]   mscratch_q, mscratch_d;
  logic [31:0]   mepc_q, mepc_d;
  logic [31:0]   mcause_q, mcause_d;
  logic [63:0]   mcycle_q, mcycle_d;
  logic [63:0]   minstret_q, minstret_d;
  logic          int_flag_q, int_flag_d;
  logic [31:0]   int_addr_q, int_addr_d;
  // bit 0 = ei, bit 1 = ti, bits 2.. = local lines; raw active-low levels
  logic [NI-1:0] irq_meta_q, irq_meta_d;
  logic [NI-1:0] irq_sync_q, irq_sync_d;

  logic          op_ecall, op_ebreak, op_mret, op_rw, op_rs, op_rc, op_imm, op_csr;
  logic [31:0]   operand_w, rdata_w, new_val_w, mip_w, pend_w, cause_w, target_w;
  logic          addr_ok_w, illegal_w, active_w, irq_hit_w, take_irq_w;
  logic          trap_w, mret_w, csr_we_w, retire_inc_w;
  logic [4:0]    irq_code_w;
  logic          unused_bits;

  assign unused_bits = ^{bus.csr_op[7], bus.pc[1:0]};

  // One-hot, active-low opcode strip
  assign op_ecall  = ~bus.csr_op[6];
  assign op_ebreak = ~bus.csr_op[5];
  assign op_mret   = ~bus.csr_op[4];
  assign op_rw     = ~bus.csr_op[3];
  assign op_rs     = ~bus.csr_op[2];
  assign op_rc     = ~bus.csr_op[1];
  assign op_imm    = ~bus.csr_op[0];
  assign op_csr    = op_rw | op_rs | op_rc;

  assign operand_w = op_imm ? {27'd0, bus.csr_zimm} : bus.gpr_qa;

  always_comb begin
    mip_w                   = 32'd0;
    mip_w[11]               = ~irq_sync_q[0];
    mip_w[7]                = ~irq_sync_q[1];
    mip_w[16 +: NUM_LCL]    = ~irq_sync_q[2 +: NUM_LCL];
  end

  // Old-value read; also tells whether the address is implemented
  always_comb begin
    rdata_w   = 32'd0;
    addr_ok_w = 1'b1;
    case (bus.csr_addr)
      ADDR_MSTATUS:   rdata_w = {19'd0, 2'b11, 3'd0, mstatus_mpie_q, 3'd0, mstatus_mie_q, 3'd0};
      ADDR_MIE:       rdata_w = mie_q;
      ADDR_MTVEC:     rdata_w = mtvec_q;
      ADDR_MSCRATCH:  rdata_w = mscratch_q;
      ADDR_MEPC:      rdata_w = mepc_q;
      ADDR_MCAUSE:    rdata_w = mcause_q;
      ADDR_MIP:       rdata_w = mip_w;
      ADDR_MCYCLE:    rdata_w = mcycle_q[31:0];
      ADDR_MCYCLEH:   rdata_w = mcycle_q[63:32];
      ADDR_MINSTRET:  rdata_w = minstret_q[31:0];
      ADDR_MINSTRETH: rdata_w = minstret_q[63:32];
      default:        addr_ok_w = 1'b0;
    endcase
  end

  always_comb begin
    if (op_rw)      new_val_w = operand_w;
    else if (op_rs) new_val_w = rdata_w | operand_w;
    else            new_val_w = rdata_w & ~operand_w;
  end

  // Interrupt select: later assignments override, so MEI > MTI > lowest local
  assign pend_w = mip_w & mie_q;
  always_comb begin
    irq_hit_w  = 1'b0;
    irq_code_w = 5'd0;
    for (int i = NUM_LCL - 1; i >= 0; i--) begin
      if (pend_w[16 + i]) begin
        irq_hit_w  = 1'b1;
        irq_code_w = 5'(16 + i);
      end
    end
    if (pend_w[7]) begin
      irq_hit_w  = 1'b1;
      irq_code_w = 5'd7;
    end
    if (pend_w[11]) begin
      irq_hit_w  = 1'b1;
      irq_code_w = 5'd11;
    end
  end

  assign active_w   = (state_q == ST_RUN) & bus.instr_valid;
  assign illegal_w  = op_csr & ~addr_ok_w;
  assign take_irq_w = irq_hit_w & mstatus_mie_q;
  assign trap_w     = active_w & (illegal_w | op_ecall | op_ebreak | take_irq_w);
  assign mret_w     = active_w & op_mret & ~trap_w;
  // rs/rc with a zero operand are pure reads; mip writes fall through the case as no-ops
  assign csr_we_w   = active_w & ~trap_w & op_csr & (op_rw | (operand_w != 32'd0));
  assign retire_inc_w = bus.retire & (state_q == ST_RUN) & ~trap_w;

  always_comb begin
    if (illegal_w)      cause_w = 32'd2;
    else if (op_ecall)  cause_w = 32'd11;
    else if (op_ebreak) cause_w = 32'd3;
    else                cause_w = {1'b1, 26'd0, irq_code_w};
  end

  // Exceptions always go to the base; only interrupts use the vector table
  always_comb begin
    target_w = {mtvec_q[31:2], 2'b00};
    if (cause_w[31] && mtvec_q[0]) begin
      target_w = target_w + {25'd0, irq_code_w, 2'b00};
    end
  end

  always_comb begin
    state_d        = ST_RUN;
    int_flag_d     = 1'b0;
    int_addr_d     = int_addr_q;
    mstatus_mie_d  = mstatus_mie_q;
    mstatus_mpie_d = mstatus_mpie_q;
    mie_d          = mie_q;
    mtvec_d        = mtvec_q;
    mscratch_d     = mscratch_q;
    mepc_d         = mepc_q;
    mcause_d       = mcause_q;
    mcycle_d       = mcycle_q + 64'd1;
    minstret_d     = minstret_q + {63'd0, retire_inc_w};
    irq_meta_d     = {lcl_irq, ti, ei};
    irq_sync_d     = irq_meta_q;

    if (trap_w) begin
      mepc_d         = {bus.pc[31:2], 2'b00};
      mcause_d       = cause_w;
      mstatus_mpie_d = mstatus_mie_q;
      mstatus_mie_d  = 1'b0;
      int_addr_d     = target_w;
      int_flag_d     = 1'b1;
      state_d        = ST_REDIR;
    end else if (mret_w) begin
      mstatus_mie_d  = mstatus_mpie_q;
      mstatus_mpie_d = 1'b1;
      int_addr_d     = mepc_q;
      int_flag_d     = 1'b1;
      state_d        = ST_REDIR;
    end else if (csr_we_w) begin
      case (bus.csr_addr)
        ADDR_MSTATUS: begin
          mstatus_mie_d  = new_val_w[3];
          mstatus_mpie_d = new_val_w[7];
        end
        ADDR_MIE:       mie_d      = new_val_w & MIE_WMASK;
        ADDR_MTVEC:     mtvec_d    = new_val_w & MTVEC_WMASK;
        ADDR_MSCRATCH:  mscratch_d = new_val_w;
        ADDR_MEPC:      mepc_d     = {new_val_w[31:2], 2'b00};
        ADDR_MCAUSE:    mcause_d   = new_val_w;
        ADDR_MCYCLE:    mcycle_d   = {mcycle_q[63:32], new_val_w};
        ADDR_MCYCLEH:   mcycle_d   = {new_val_w, mcycle_q[31:0]};
        ADDR_MINSTRET:  minstret_d = {minstret_q[63:32], new_val_w};
        ADDR_MINSTRETH: minstret_d = {new_val_w, minstret_q[31:0]};
        default: ;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q        <= ST_RUN;
      mstatus_mie_q  <= 1'b0;
      mstatus_mpie_q <= 1'b0;
      mie_q          <= 32'd0;
      mtvec_q        <= MTVEC_RESET & MTVEC_WMASK;
      mscratch_q     <= 32'd0;
      mepc_q         <= 32'd0;
      mcause_q       <= 32'd0;
      mcycle_q       <= 64'd0;
      minstret_q     <= 64'd0;
      int_flag_q     <= 1'b0;
      int_addr_q     <= 32'd0;
      irq_meta_q     <= '1;
      irq_sync_q     <= '1;
    end else begin
      state_q        <= state_d;
      mstatus_mie_q  <= mstatus_mie_d;
      mstatus_mpie_q <= mstatus_mpie_d;
      mie_q          <= mie_d;
      mtvec_q        <= mtvec_d;
      mscratch_q     <= mscratch_d;
      mepc_q         <= mepc_d;
      mcause_q       <= mcause_d;
      mcycle_q       <= mcycle_d;
      minstret_q     <= minstret_d;
      int_flag_q     <= int_flag_d;
      int_addr_q     <= int_addr_d;
      irq_meta_q     <= irq_meta_d;
      irq_sync_q     <= irq_sync_d;
    end
  end

  assign bus.csr_rdata = rdata_w;
  assign bus.int_flag  = int_flag_q;
  assign bus.int_addr  = int_addr_q;

endmodule
`default_nettype wire

// File: tb/tb_csr_trap_unit.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module      : tb_csr_trap_unit                                             |
// | Description : Self-checking bench for csr_trap_unit. A behavioural CSR     |
// |               model is compared against the DUT on every falling edge;     |
// |               directed sequences pin the model with literal values.        |
// | Revision    : 1.0  initial release                                         |
// +----------------------------------------------------------------------------+
module tb_csr_trap_unit;
  localparam int NUM_LCL = 4;

  localparam logic [7:0] NOP    = 8'hFF;
  localparam logic [7:0] CSRRW  = 8'hF7;
  localparam logic [7:0] CSRRWI = 8'hF6;
  localparam logic [7:0] CSRRS  = 8'hFB;
  localparam logic [7:0] CSRRSI = 8'hFA;
  localparam logic [7:0] CSRRCI = 8'hFC;
  localparam logic [7:0] ECALL  = 8'hBF;
  localparam logic [7:0] EBREAK = 8'hDF;
  localparam logic [7:0] MRET   = 8'hEF;

  logic               clk;
  logic               rst_n;
  logic               ei;
  logic               ti;
  logic [NUM_LCL-1:0] lcl_irq;
  int                 total;
  int                 bad;

  csr_trap_unit_if bus ();

  csr_trap_unit #(.NUM_LCL(NUM_LCL), .VECTORED(1'b1), .MTVEC_RESET(32'h0000_0100)) dut (
    .clk     (clk),
    .rst_n   (rst_n),
    .ei      (ei),
    .ti      (ti),
    .lcl_irq (lcl_irq),
    .bus     (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // ---------------- behavioural model ----------------
  logic [31:0]        m_mstatus, m_mie, m_mtvec, m_mscratch, m_mepc, m_mcause, m_mip, m_addr;
  logic [63:0]        m_mcycle, m_minstret;
  logic               m_flag;
  logic               m_prev_ei, m_prev_ti;
  logic [NUM_LCL-1:0] m_prev_lcl;

  function automatic logic is_mapped(input logic [11:0] a);
    return (a == 12'h300) || (a == 12'h304) || (a == 12'h305) || (a == 12'h340) ||
           (a == 12'h341) || (a == 12'h342) || (a == 12'h344) || (a == 12'hB00) ||
           (a == 12'hB80) || (a == 12'hB02) || (a == 12'hB82);
  endfunction

  function automatic logic [31:0] model_read(input logic [11:0] a);
    case (a)
      12'h300: return m_mstatus;
      12'h304: return m_mie;
      12'h305: return m_mtvec;
      12'h340: return m_mscratch;
      12'h341: return m_mepc;
      12'h342: return m_mcause;
      12'h344: return m_mip;
      12'hB00: return m_mcycle[31:0];
      12'hB80: return m_mcycle[63:32];
      12'hB02: return m_minstret[31:0];
      12'hB82: return m_minstret[63:32];
      default: return 32'd0;
    endcase
  endfunction

  task automatic model_reset();
    m_mstatus = 32'h1800; m_mie = 0; m_mtvec = 32'h100; m_mscratch = 0;
    m_mepc = 0; m_mcause = 0; m_mip = 0; m_addr = 0; m_flag = 0;
    m_mcycle = 0; m_minstret = 0;
    m_prev_ei = 1; m_prev_ti = 1; m_prev_lcl = '1;
  endtask

  task automatic model_step();
    logic        was_redir, is_rw, is_rs, is_rc, is_csr, trap, intr, do_write, found;
    logic [31:0] opnd, oldv, newv, pend, cause, tgt;
    logic [63:0] cyc_n, ins_n;
    was_redir = m_flag;
    m_flag    = 0;
    is_rw  = !bus.csr_op[3];
    is_rs  = !bus.csr_op[2];
    is_rc  = !bus.csr_op[1];
    is_csr = is_rw || is_rs || is_rc;
    opnd   = bus.csr_op[0] ? bus.gpr_qa : {27'd0, bus.csr_zimm};
    oldv   = model_read(bus.csr_addr);
    trap = 0; intr = 0; do_write = 0; cause = 0; newv = 0;
    if (bus.instr_valid && !was_redir) begin
      pend = m_mip & m_mie;
      if (is_csr && !is_mapped(bus.csr_addr)) begin trap = 1; cause = 2; end
      else if (!bus.csr_op[6]) begin trap = 1; cause = 11; end
      else if (!bus.csr_op[5]) begin trap = 1; cause = 3; end
      else if (m_mstatus[3] && pend != 0) begin
        trap = 1; intr = 1;
        if (pend[11]) cause = 32'h8000_000B;
        else if (pend[7]) cause = 32'h8000_0007;
        else begin
          found = 0;
          for (int i = 0; i < NUM_LCL; i++)
            if (!found && pend[16 + i]) begin found = 1; cause = 32'h8000_0000 + 32'(16 + i); end
        end
      end
      if (trap) begin
        tgt = m_mtvec & ~32'h3;
        if (intr && m_mtvec[0]) tgt = tgt + 4 * (cause & 32'h1F);
        m_mepc    = bus.pc & ~32'h3;
        m_mcause  = cause;
        m_mstatus = 32'h1800 | (m_mstatus[3] ? 32'h80 : 32'h0);
        m_addr    = tgt;
        m_flag    = 1;
      end else if (!bus.csr_op[4]) begin
        m_mstatus = 32'h1880 | (m_mstatus[7] ? 32'h8 : 32'h0);
        m_addr    = m_mepc;
        m_flag    = 1;
      end else if (is_csr && (is_rw || opnd != 0)) begin
        do_write = 1;
        newv = is_rw ? opnd : (is_rs ? (oldv | opnd) : (oldv & ~opnd));
      end
    end
    cyc_n = m_mcycle + 1;
    ins_n = m_minstret + ((bus.retire && !was_redir && !trap) ? 64'd1 : 64'd0);
    if (do_write) begin
      case (bus.csr_addr)
        12'h300: m_mstatus  = 32'h1800 | (newv & 32'h88);
        12'h304: m_mie      = newv & (32'h888 | (32'hF << 16));
        12'h305: m_mtvec    = newv & ~32'h2;
        12'h340: m_mscratch = newv;
        12'h341: m_mepc     = newv & ~32'h3;
        12'h342: m_mcause   = newv;
        12'hB00: cyc_n      = {m_mcycle[63:32], newv};
        12'hB80: cyc_n      = {newv, m_mcycle[31:0]};
        12'hB02: ins_n      = {m_minstret[63:32], newv};
        12'hB82: ins_n      = {newv, m_minstret[31:0]};
        default: ;
      endcase
    end
    m_mcycle   = cyc_n;
    m_minstret = ins_n;
    // pending bits seen after this edge reflect the lines as they were one edge earlier
    m_mip = (m_prev_ei ? 32'h0 : 32'h800) | (m_prev_ti ? 32'h0 : 32'h80);
    for (int i = 0; i < NUM_LCL; i++)
      if (!m_prev_lcl[i]) m_mip = m_mip | (32'h1 << (16 + i));
    m_prev_ei = ei; m_prev_ti = ti; m_prev_lcl = lcl_irq;
  endtask

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) model_reset();
    else        model_step();
  end

  // ---------------- checking ----------------
  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %08h want %08h", nm, act, exp);
    end
  endtask

  always @(negedge clk) begin
    if (rst_n === 1'b1) begin
      chk("cmp_int_flag", {31'd0, bus.int_flag}, {31'd0, m_flag});
      if (m_flag) chk("cmp_int_addr", bus.int_addr, m_addr);
      chk("cmp_csr_rdata", bus.csr_rdata, model_read(bus.csr_addr));
    end
  end

  // ---------------- stimulus ----------------
  task automatic drive(input logic v, input logic [7:0] op, input logic [11:0] a,
                       input logic [31:0] q, input logic [4:0] z, input logic [31:0] p,
                       input logic r);
    bus.instr_valid = v; bus.csr_op = op; bus.csr_addr = a;
    bus.gpr_qa = q; bus.csr_zimm = z; bus.pc = p; bus.retire = r;
    @(posedge clk); #1;
  endtask

  task automatic idle();
    drive(1'b0, NOP, 12'h300, 32'd0, 5'd0, 32'd0, 1'b0);
  endtask

  task automatic rd(input logic [11:0] a, input logic [31:0] exp, input string nm);
    bus.instr_valid = 1'b0; bus.csr_op = NOP; bus.retire = 1'b0; bus.csr_addr = a;
    #2;
    chk(nm, bus.csr_rdata, exp);
    @(posedge clk); #1;
  endtask

  task automatic redir_chk(input logic [31:0] a, input string nm);
    chk({nm, "_flag"}, {31'd0, bus.int_flag}, 32'd1);
    chk({nm, "_addr"}, bus.int_addr, a);
    idle();
    chk({nm, "_flag_drop"}, {31'd0, bus.int_flag}, 32'd0);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: got timeout want finish");
    $fatal(1, "watchdog");
  end

  initial begin
    total = 0; bad = 0;
    rst_n = 1'b0; ei = 1'b1; ti = 1'b1; lcl_irq = '1;
    bus.instr_valid = 1'b0; bus.csr_op = NOP; bus.csr_addr = 12'h300;
    bus.gpr_qa = 0; bus.csr_zimm = 0; bus.pc = 0; bus.retire = 1'b0;
    repeat (3) @(posedge clk);
    #1 rst_n = 1'b1;

    // reset values and free-running mcycle
    rd(12'hB00, 32'd0, "mcycle_0");
    idle(); idle();
    rd(12'hB00, 32'd3, "mcycle_3");
    rd(12'h300, 32'h1800, "rst_mstatus");
    rd(12'h305, 32'h100, "rst_mtvec");
    rd(12'h304, 32'h0, "rst_mie");
    rd(12'h341, 32'h0, "rst_mepc");
    rd(12'h342, 32'h0, "rst_mcause");
    rd(12'h340, 32'h0, "rst_mscratch");
    rd(12'h344, 32'h0, "rst_mip");
    rd(12'hB02, 32'h0, "rst_minstret");

    // external interrupt, direct mode
    drive(1, CSRRS, 12'h304, 32'h800, 0, 32'h10, 1);
    drive(1, CSRRSI, 12'h300, 0, 5'd8, 32'h14, 1);
    rd(12'h304, 32'h800, "mie_mei");
    rd(12'h300, 32'h1808, "mstatus_mie");
    ei = 1'b0;
    idle(); idle();
    rd(12'h344, 32'h800, "mip_mei");
    drive(1, NOP, 12'h300, 0, 0, 32'h40, 1);
    redir_chk(32'h100, "mei_trap");
    rd(12'h341, 32'h40, "mei_mepc");
    rd(12'h342, 32'h8000_000B, "mei_mcause");
    rd(12'h300, 32'h1880, "mei_mstatus");
    rd(12'hB02, 32'd2, "minstret_trap_suppressed");
    ei = 1'b1;
    idle(); idle();

    // vectored mtvec, MEI beats MTI, then mret
    drive(1, CSRRW, 12'h305, 32'h201, 0, 32'h20, 0);
    rd(12'h305, 32'h201, "mtvec_vec");
    drive(1, CSRRS, 12'h304, 32'h80, 0, 32'h24, 0);
    drive(1, CSRRSI, 12'h300, 0, 5'd8, 32'h28, 0);
    rd(12'h300, 32'h1888, "mstatus_pre_vec");
    ei = 1'b0; ti = 1'b0;
    idle(); idle();
    rd(12'h344, 32'h880, "mip_both");
    drive(1, NOP, 12'h300, 0, 0, 32'h44, 0);
    redir_chk(32'h22C, "vec_mei");
    rd(12'h342, 32'h8000_000B, "vec_mcause");
    rd(12'h300, 32'h1880, "vec_mstatus");
    ei = 1'b1; ti = 1'b1;
    idle(); idle();
    drive(1, MRET, 12'h300, 0, 0, 32'h60, 0);
    redir_chk(32'h44, "mret");
    rd(12'h300, 32'h1888, "mret_mstatus");

    // ecall with MIE=0, then illegal CSR
    drive(1, CSRRCI, 12'h300, 0, 5'd8, 32'h70, 0);
    drive(1, ECALL, 12'h300, 0, 0, 32'h80, 0);
    redir_chk(32'h200, "ecall");
    rd(12'h342, 32'd11, "ecall_mcause");
    rd(12'h341, 32'h80, "ecall_mepc");
    rd(12'h300, 32'h1800, "ecall_mstatus");
    drive(1, CSRRW, 12'h7C0, 32'hDEAD, 0, 32'h84, 0);
    redir_chk(32'h200, "illegal");
    rd(12'h342, 32'd2, "illegal_mcause");
    rd(12'h341, 32'h84, "illegal_mepc");
    rd(12'h340, 32'h0, "illegal_mscratch");

    // interrupt pre-empts a CSR write
    drive(1, CSRRSI, 12'h300, 0, 5'd8, 32'h88, 0);
    ti = 1'b0;
    idle(); idle();
    drive(1, CSRRW, 12'h340, 32'h1234, 0, 32'h90, 0);
    redir_chk(32'h21C, "mti_pre");
    rd(12'h340, 32'h0, "mti_mscratch_kept");
    rd(12'h342, 32'h8000_0007, "mti_mcause");
    ti = 1'b1;
    idle(); idle();

    // mie write mask, local interrupts lowest index first
    drive(1, CSRRW, 12'h304, 32'hFFFF_FFFF, 0, 32'h94, 0);
    rd(12'h304, 32'h000F_0888, "mie_mask");
    drive(1, CSRRSI, 12'h300, 0, 5'd8, 32'h98, 0);
    lcl_irq = 4'b1100;
    idle(); idle();
    rd(12'h344, 32'h0003_0000, "mip_lcl");
    drive(1, NOP, 12'h300, 0, 0, 32'hA0, 0);
    redir_chk(32'h240, "lcl0");
    rd(12'h342, 32'h8000_0010, "lcl_mcause");
    lcl_irq = '1;
    idle(); idle();
    drive(1, CSRRW, 12'h344, 32'hFFFF_FFFF, 0, 32'hA4, 0);
    chk("mip_write_noop_flag", {31'd0, bus.int_flag}, 32'd0);
    rd(12'h344, 32'h0, "mip_write_ignored");

    // counters: carry, overrides, zero-operand set
    drive(1, CSRRW, 12'hB00, 32'hFFFF_FFFF, 0, 32'hB0, 0);
    rd(12'hB00, 32'hFFFF_FFFF, "mcycle_lo_max");
    rd(12'hB80, 32'd1, "mcycleh_carry");
    drive(1, CSRRWI, 12'hB00, 0, 5'd5, 32'hB4, 0);
    rd(12'hB00, 32'd5, "mcycle_5");
    rd(12'hB00, 32'd6, "mcycle_6");
    drive(1, CSRRS, 12'hB00, 32'd0, 0, 32'hB8, 0);
    rd(12'hB00, 32'd8, "mcycle_rs0");
    drive(1, CSRRW, 12'hB82, 32'hFFFF_FFFF, 0, 32'hBC, 0);
    drive(1, CSRRW, 12'hB02, 32'hFFFF_FFFF, 0, 32'hBC, 0);
    rd(12'hB02, 32'hFFFF_FFFF, "minstret_max");
    drive(0, NOP, 12'hB02, 0, 0, 0, 1);
    rd(12'hB02, 32'd0, "minstret_wrap_lo");
    rd(12'hB82, 32'd0, "minstret_wrap_hi");

    // asynchronous reset while redirecting
    drive(1, EBREAK, 12'h300, 0, 0, 32'hC0, 0);
    chk("ebreak_flag", {31'd0, bus.int_flag}, 32'd1);
    chk("ebreak_addr", bus.int_addr, 32'h200);
    bus.instr_valid = 1'b0; bus.csr_op = NOP; bus.csr_addr = 12'h300;
    #1 rst_n = 1'b0;
    #1;
    chk("async_rst_flag", {31'd0, bus.int_flag}, 32'd0);
    chk("async_rst_addr", bus.int_addr, 32'd0);
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;
    rd(12'h300, 32'h1800, "rst2_mstatus");
    rd(12'h305, 32'h100, "rst2_mtvec");
    rd(12'h342, 32'h0, "rst2_mcause");

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
`default_nettype wire
